// File: rtl/deserializer_8bit.sv
`default_nettype none
// ============================================================================
// Module      : deserializer_8bit
// Description : Serial-to-parallel converter. Assembles 8 accepted serial
//               bits into a registered byte with a valid/ready output
//               handshake, sticky overrun flag and synchronous abort.
// Revision    : 1.0 - initial release
// ============================================================================
module deserializer_8bit #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sin,
    input  logic       sin_valid,
    input  logic       clear,
    input  logic       out_ready,
    output logic [7:0] pout,
    output logic       pout_valid,
    output logic [2:0] bit_idx,
    output logic       busy,
    output logic       overrun
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    localparam logic [2:0] C_LAST_IDX = 3'd7;

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_shift;
    logic [7:0] r_pout;
    logic       r_pout_valid;
    logic [2:0] r_bit_idx;
    logic       r_overrun;

    logic [2:0] w_slot;
    logic [7:0] w_word;
    logic       w_accept;
    logic       w_complete;
    logic       w_load;

    // Bit ordering is fixed at elaboration: map the running index to a slot.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_slot = C_LAST_IDX - r_bit_idx;
        end else begin : g_lsb_first
            assign w_slot = r_bit_idx;
        end
    endgenerate

    // State register; reset discards any partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic plus the per-edge accept/complete/load decisions.
    always_comb begin
        w_state_next   = r_state;
        w_accept       = sin_valid & ~clear;
        w_complete     = w_accept & (r_bit_idx == C_LAST_IDX);
        // A finished word may enter the output register if it is empty or
        // being consumed on this very edge; otherwise it is dropped.
        w_load         = w_complete & (~r_pout_valid | out_ready);
        w_word         = r_shift;
        w_word[w_slot] = sin;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_RECV;
                end
            end
            ST_RECV: begin
                if (clear || w_complete) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: shift slots, bit index, output word and sticky overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift      <= 8'h00;
            r_bit_idx    <= 3'd0;
            r_pout       <= 8'h00;
            r_pout_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (clear) begin
                r_bit_idx <= 3'd0;
                r_shift   <= 8'h00;
                r_overrun <= 1'b0;
            end else if (w_accept) begin
                r_bit_idx <= r_bit_idx + 3'd1;
                // Zero the shift slots on completion so no stale bits leak.
                r_shift   <= w_complete ? 8'h00 : w_word;
                if (w_complete && !w_load) begin
                    r_overrun <= 1'b1;
                end
            end
            // Output side is independent of clear: load wins over consume.
            if (w_load) begin
                r_pout       <= w_word;
                r_pout_valid <= 1'b1;
            end else if (r_pout_valid && out_ready) begin
                r_pout_valid <= 1'b0;
            end
        end
    end

    assign pout       = r_pout;
    assign pout_valid = r_pout_valid;
    assign bit_idx    = r_bit_idx;
    assign busy       = (r_state == ST_RECV);
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: doc/deserializer_8bit.md
DESERIALIZER_8BIT -- requirements
Module: deserializer_8bit

Interface
REQ-001 Parameter: MSB_FIRST, 0, bit ordering; 0 = first accepted serial bit lands in pout[0], 1 = first accepted bit lands in pout[7].
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 sin  input  1  serial data bit.
REQ-005 sin_valid  input  1  sin is sampled on a rising edge only when sin_valid=1.
REQ-006 clear  input  1  synchronous abort; discards the partial word and clears overrun.
REQ-007 out_ready  input  1  consumer accepts pout when pout_valid=1 and out_ready=1.
REQ-008 pout  output  8  assembled parallel word, registered.
REQ-009 pout_valid  output  1  pout holds an unconsumed word.
REQ-010 bit_idx  output  3  slot for the next serial bit, 3'b000..3'b111, registered.
REQ-011 busy  output  1  partial word in progress (state RECV).
REQ-012 overrun  output  1  sticky; a completed word was dropped.

Function
REQ-013 FSM states: IDLE (bit_idx=0, no partial data) and RECV (1-7 bits captured).
REQ-014 IDLE->RECV on an accepted bit (sin_valid=1) with clear=0; RECV->IDLE on the 8th accepted bit or on clear=1.
REQ-015 Accepted bit goes to internal shift slot bit_idx (MSB_FIRST=0) or 7-bit_idx (MSB_FIRST=1); bit_idx increments by 1, wrapping 3'b111->3'b000 on the 8th bit.
REQ-016 sin_valid=0: bit_idx, partial data and state hold.
REQ-017 On the edge accepting the 8th bit, if pout_valid=0 or out_ready=1, the full word loads into pout and pout_valid=1 from that edge (zero idle cycles; back-to-back words sustain one word per 8 accepted bits).
REQ-018 Handshake: pout_valid=1 and out_ready=1 with no word completing -> pout_valid=0 next edge; pout holds its last value.
REQ-019 Simultaneous completion and handshake: new word loads, pout_valid stays 1.
REQ-020 Completion while pout_valid=1 and out_ready=0: new word dropped, pout unchanged, overrun=1 next edge, bit_idx wraps to 0.
REQ-021 overrun stays 1 until clear=1 or reset.
REQ-022 clear=1 has priority over sin_valid the same edge: bit_idx=0, state IDLE, partial bits discarded, overrun=0, bit not accepted; pout and pout_valid are not affected.
REQ-023 busy=1 exactly when state is RECV.
REQ-024 The RTL SHALL drive no X on any output after reset; all case statements SHALL have a default.

Reset
REQ-025 rst_n=0 asynchronously forces pout=8'h00, pout_valid=0, bit_idx=3'b000, busy=0, overrun=0, state IDLE, internal shift register=0.
REQ-026 Reset asserted mid-word SHALL discard the partial word; the first accepted bit after rst_n rises lands in slot 0.

Verification
REQ-027 MSB_FIRST=0, out_ready=1, 8 consecutive accepted bits 1,0,1,0,0,0,0,1 -> pout=8'h85, pout_valid=1 after the 8th edge, bit_idx=0, busy=0.
REQ-028 MSB_FIRST=1, same bit sequence -> pout=8'hA1.
REQ-029 Word 8'h3C completes, out_ready=0, second word 8'hFF fed in full -> pout stays 8'h3C, overrun=1; then clear=1 -> overrun=0, pout_valid still 1.
REQ-030 sin_valid toggled 1/0 every cycle over 16 cycles -> exactly one word, bit_idx holds during gaps.
REQ-031 rst_n pulsed low after 5 bits, then 8 new bits of 8'h5A -> pout=8'h5A with no residue from the aborted word; clear after 3 bits behaves identically.
REQ-032 Continuous stream of words 8'h01, 8'h02 with out_ready=1, handshake on the same edge as completion -> pout_valid stays 1 and pout steps 8'h01->8'h02, overrun=0.
